// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit.
// Holds op encodings, the FSM state type and the default datapath width.
// Optional build macro used by the top: MULDIV_FAST_MUL_EN.
package mips_muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/mips_div_core.sv
// One restoring-division step on unsigned magnitudes.
// Purely combinational: shifts the next dividend bit into the partial
// remainder, trial-subtracts the divisor and shifts the quotient bit in.
module mips_div_core
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            keep;

  // rem < divisor always holds, so shifted < 2*divisor and the W+1 bit
  // difference never overflows; its top bit is a clean borrow flag.
  always_comb begin
    shifted  = {rem, quo[DATA_W-1]};
    diff     = shifted - {1'b0, divisor};
    keep     = diff[DATA_W];
    rem_next = keep ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], ~keep};
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Operations run on magnitudes, one bit per cycle, with signs fixed in FIX.
// Build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              hi_wena,
  input  logic              lo_wena,
  input  logic [DATA_W-1:0] mt_data,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  // acc_hi/acc_lo hold {product} for multiply and {remainder, quotient} for divide.
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd_b;
  logic              neg_hi, neg_lo, is_mul, dz_flag;

  logic              signed_op, rs_neg, rt_neg, rt_zero, last_iter;
  logic [DATA_W-1:0] rs_abs, rt_abs;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] rem_next, quo_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] fix_hi, fix_lo;

  assign busy = (state != IDLE);

  // Operand magnitudes and sign decode for the launch cycle.
  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[DATA_W-1];
    rt_neg    = signed_op & rt_data[DATA_W-1];
    rs_abs    = rs_neg ? (~rs_data + 1'b1) : rs_data;
    rt_abs    = rt_neg ? (~rt_data + 1'b1) : rt_data;
    rt_zero   = (rt_data == '0);
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  // Shift-add multiply step: add multiplicand on multiplier LSB, shift right.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  end

  mips_div_core #(.DATA_W(DATA_W)) u_div_core (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (opnd_b),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign correction of the magnitude result before it is committed to HI/LO.
  always_comb begin
    prod_fix = neg_lo ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    if (is_mul) begin
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end else begin
      fix_hi = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
      fix_lo = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; divide-by-zero (and fast multiply) jump straight to FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
        if (op[1])      state_nxt = rt_zero ? FIX : DIV;
        else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_nxt = FIX;
`else
                        state_nxt = MUL;
`endif
        end
      end
      MUL:  if (last_iter) state_nxt = FIX;
      DIV:  if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, HI/LO registers and completion pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      neg_hi      <= 1'b0;
      neg_lo      <= 1'b0;
      is_mul      <= 1'b0;
      dz_flag     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land even alongside start; FIX overwrites them later.
          if (hi_wena) hi <= mt_data;
          if (lo_wena) lo <= mt_data;
          if (start) begin
            cnt     <= '0;
            is_mul  <= ~op[1];
            dz_flag <= 1'b0;
            if (op[1]) begin
              opnd_b <= rt_abs;
              if (rt_zero) begin
                // Preload the architected divide-by-zero result; no sign fix.
                acc_hi  <= rs_data;
                acc_lo  <= '1;
                neg_hi  <= 1'b0;
                neg_lo  <= 1'b0;
                dz_flag <= 1'b1;
              end else begin
                acc_hi <= '0;
                acc_lo <= rs_abs;
                neg_hi <= rs_neg;
                neg_lo <= rs_neg ^ rt_neg;
              end
            end else begin
              opnd_b <= rs_abs;
              neg_hi <= rs_neg ^ rt_neg;
              neg_lo <= rs_neg ^ rt_neg;
`ifdef MULDIV_FAST_MUL_EN
              {acc_hi, acc_lo} <= {{DATA_W{1'b0}}, rs_abs} * {{DATA_W{1'b0}}, rt_abs};
`else
              acc_hi <= '0;
              acc_lo <= rt_abs;
`endif
            end
          end
        end
        MUL: begin
          acc_hi <= mul_sum[DATA_W:1];
          acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          cnt    <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc_hi <= rem_next;
          acc_lo <= quo_next;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dz_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit.
// Expected HI/LO/flag/latency are computed by a behavioural model at launch,
// queued, and compared when the DUT pulses done.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_data = '0, rt_data = '0, mt_data = '0;
  logic         hi_wena = 1'b0, lo_wena = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           c0;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  mips_muldiv_unit #(.DATA_W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hi_wena     (hi_wena),
    .lo_wena     (lo_wena),
    .mt_data     (mt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint x, y, q, m;
    logic [63:0] u, v;
    r.dz = 1'b0;
    r.c0 = 0;
    r.lat = MUL_LAT;
    case (o)
      OP_MULT: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        u = x * y;
        r.hi = u[63:32]; r.lo = u[31:0];
      end
      OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        r.hi = u[63:32]; r.lo = u[31:0];
      end
      default: begin
        r.lat = W + 1;
        if (b == '0) begin
          r.lat = 1; r.dz = 1'b1; r.hi = a; r.lo = '1;
        end else begin
          if (o == OP_DIV) begin
            x = longint'($signed(a)); y = longint'($signed(b));
          end else begin
            x = longint'({32'b0, a}); y = longint'({32'b0, b});
          end
          q = x / y; m = x % y;
          u = q; v = m;
          r.lo = u[31:0]; r.hi = v[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done (or stray div_by_zero) must match the oldest launch.
  always @(negedge clock) begin
    if (!reset && (done || div_by_zero)) begin
      chk("done_with_dz", done, 1);
      chk("result_pending", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("div_by_zero", div_by_zero, mon_e.dz);
        chk("latency", cyc - mon_e.c0, mon_e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wr_hi, input logic [W-1:0] md);
    exp_t e;
    @(negedge clock);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    hi_wena = wr_hi; mt_data = md;
    e = model(o, a, b);
    @(negedge clock);
    start = 1'b0; hi_wena = 1'b0;
    e.c0 = cyc;
    sbq.push_back(e);
    chk("busy_after_start", busy, 1);
    last_hi = e.hi; last_lo = e.lo;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("idle_within_budget", k < 200, 1);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(o, a, b, 1'b0, '0);
    wait_idle();
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ph, pl, a, b;
    logic [1:0]   o;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;

    // MTHI / MTLO in idle
    @(negedge clock);
    mt_data = 32'hCAFE_0001; hi_wena = 1'b1;
    @(negedge clock);
    hi_wena = 1'b0;
    chk("mthi", hi, 32'hCAFE_0001);
    mt_data = 32'h1234_BEEF; lo_wena = 1'b1;
    @(negedge clock);
    lo_wena = 1'b0;
    chk("mtlo", lo, 32'h1234_BEEF);

    // Directed cases with hand-derived constants
    run(OP_MULT, 32'd5, 32'hFFFF_FFFD);
    chk("tp_mult_hi", hi, 32'hFFFF_FFFF);
    chk("tp_mult_lo", lo, 32'hFFFF_FFF1);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("tp_multu_hi", hi, 32'h0000_0001);
    chk("tp_multu_lo", lo, 32'hFFFF_FFFE);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("tp_div_lo", lo, 32'hFFFF_FFFD);
    chk("tp_div_hi", hi, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'd100, 32'd7);
    chk("tp_divu_lo", lo, 32'h0000_000E);
    chk("tp_divu_hi", hi, 32'h0000_0002);
    run(OP_DIV, 32'h0000_1234, 32'd0);
    chk("tp_dz_lo", lo, 32'hFFFF_FFFF);
    chk("tp_dz_hi", hi, 32'h0000_1234);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("tp_ovf_lo", lo, 32'h8000_0000);
    chk("tp_ovf_hi", hi, 32'h0000_0000);
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run(OP_MULT, 32'h8000_0000, 32'h8000_0000);

    // Start and MTHI while busy are ignored; HI/LO hold until completion
    ph = last_hi; pl = last_lo;
    start_op(OP_MULT, 32'h0001_2345, 32'h0000_0100, 1'b0, '0);
    repeat (4) @(negedge clock);
    if (busy) begin
      op = OP_DIVU; rs_data = 32'd77; rt_data = 32'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("hold_hi_mid", hi, ph);
      chk("hold_lo_mid", lo, pl);
    end
    repeat (4) @(negedge clock);
    if (busy) begin
      mt_data = 32'hDEAD_DEAD; hi_wena = 1'b1;
      @(negedge clock);
      hi_wena = 1'b0;
      chk("mthi_ignored_busy", hi, ph);
    end
    wait_idle();
    @(negedge clock);
    chk("interfere_lo", lo, 32'h0123_4500);
    chk("interfere_hi", hi, 32'h0000_0000);

    // MTHI coincident with start lands, then gets overwritten by the result
    start_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'h5555_AAAA);
    chk("mthi_with_start", hi, 32'h5555_AAAA);
    wait_idle();
    @(negedge clock);
    chk("mthi_overwritten", hi, 32'h0000_0000);

    // Reset in the middle of a divide: abort, no done
    @(negedge clock);
    op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run(OP_DIVU, 32'd9, 32'd3);
    chk("post_abort_lo", lo, 32'd3);
    chk("post_abort_hi", hi, 32'd0);

    // Random mix, including some zero divisors
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 3) ? '0 : $urandom;
      if (i % 5 == 1) b = 32'($urandom_range(1, 15));
      run(o, a, b);
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
